// File: rtl/sr_decode_stage.sv
// ---------------------------------------------------------------------------
// sr_decode_stage
//
// Registered instruction-decode stage for the schoolRISCV core. It sits
// between fetch and execute. Each instruction word accepted over the input
// valid/ready handshake is split into its raw register and function fields.
// The stage also classifies the instruction format, selects the matching
// immediate and sign-extends it to XLEN, and flags encodings it does not
// support. The decoded bundle is presented one cycle after the input
// transfer.
//
// Parameters
//   XLEN : datapath width (32 or 64); sets the width of in_pc, out_pc, out_imm
//   SKID : 0 = single pipeline register, in_ready combinational
//          1 = main + skid register, in_ready registered (skid empty)
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   flush           : synchronous flush; drops everything held and offered
//   in_valid/ready  : upstream handshake
//   in_instr, in_pc : fetched instruction word and its PC
//   out_valid/ready : downstream handshake
//   out_pc          : PC of the decoded instruction
//   out_op/rd/f3/rs1/rs2/f7 : raw slices of the registered instruction
//   out_imm         : selected immediate, sign-extended from instr[31]
//   out_imm_type    : R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   out_illegal     : unsupported / illegal encoding (still passed along)
// ---------------------------------------------------------------------------
module sr_decode_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_f3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_f7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Instruction format from the opcode. Anything without the 32-bit
    // encoding marker in bits [1:0] is illegal regardless of the rest.
    function automatic logic [2:0] fmt_of(input logic [31:0] ins);
        logic [2:0] f;
        f = FMT_ILL;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'b0000011,
                7'b0010011,
                7'b1100111: f = FMT_I;
                7'b0100011: f = FMT_S;
                7'b1100011: f = FMT_B;
                7'b0110111,
                7'b0010111: f = FMT_U;
                7'b1101111: f = FMT_J;
                7'b0110011: f = FMT_R;
                default:    f = FMT_ILL;
            endcase
        end
        return f;
    endfunction

    // Immediate assembled as a signed 32-bit value first, then widened.
    // The widening cast carries instr[31] up to XLEN, so U-type on a
    // 64-bit core is sign-extended from bit 31 as well.
    function automatic logic signed [XLEN-1:0] imm_of(input logic [31:0] ins,
                                                      input logic [2:0]  fmt);
        logic signed [31:0] v;
        case (fmt)
            FMT_I:   v = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                          ins[11:8], 1'b0};
            FMT_U:   v = {ins[31:12], 12'b0};
            FMT_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                          ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return XLEN'(v);
    endfunction

    // ---- stage p0: combinational decode of the offered instruction ----
    logic [2:0]      fmt_p0;
    logic [XLEN-1:0] imm_p0;
    logic            ill_p0;

    always_comb begin
        fmt_p0 = fmt_of(in_instr);
        imm_p0 = imm_of(in_instr, fmt_p0);
        ill_p0 = (fmt_p0 == FMT_ILL);
    end

    // ---- stage p1: main output register and optional skid register ----
    logic            vld_p1;
    logic [31:0]     instr_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] imm_p1;
    logic [2:0]      fmt_p1;
    logic            ill_p1;

    logic            vld_sk;
    logic [31:0]     instr_sk;
    logic [XLEN-1:0] pc_sk;
    logic [XLEN-1:0] imm_sk;
    logic [2:0]      fmt_sk;
    logic            ill_sk;

    logic            rdy_q;

    logic            in_fire;
    logic            out_fire;
    logic            vld_p1_d;
    logic            vld_sk_d;
    logic            rdy_d;
    logic            ld_main;
    logic            main_from_skid;
    logic            ld_skid;

    // Without a skid buffer the stage can take a new word whenever the
    // current one leaves (or there is none). With a skid buffer, in_ready is
    // purely a flop so no combinational path runs from out_ready upstream.
    assign in_ready = (SKID != 0) ? rdy_q : (!vld_p1 || out_ready);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p1 && out_ready;

    always_comb begin
        vld_p1_d       = vld_p1;
        vld_sk_d       = vld_sk;
        ld_main        = 1'b0;
        main_from_skid = 1'b0;
        ld_skid        = 1'b0;

        if (flush) begin
            // Anything held or offered this cycle is discarded; an offered
            // word is still consumed because in_ready is left untouched.
            vld_p1_d = 1'b0;
            vld_sk_d = 1'b0;
        end else if (SKID == 0) begin
            if (in_fire) begin
                ld_main  = 1'b1;
                vld_p1_d = 1'b1;
            end else if (out_fire) begin
                vld_p1_d = 1'b0;
            end
        end else begin
            if (!vld_p1 || out_ready) begin
                // Main is free at this edge. The skid entry is older than
                // anything on the input, and in_ready is low while the skid
                // is occupied, so the two sources never compete.
                if (vld_sk) begin
                    ld_main        = 1'b1;
                    main_from_skid = 1'b1;
                    vld_p1_d       = 1'b1;
                    vld_sk_d       = 1'b0;
                end else if (in_fire) begin
                    ld_main  = 1'b1;
                    vld_p1_d = 1'b1;
                end else begin
                    vld_p1_d = 1'b0;
                end
            end else if (in_fire) begin
                // Main stalled and full: park the word in the skid entry.
                ld_skid  = 1'b1;
                vld_sk_d = 1'b1;
            end
        end

        rdy_d = !vld_sk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_sk <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            vld_p1 <= vld_p1_d;
            vld_sk <= vld_sk_d;
            rdy_q  <= rdy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= '0;
            pc_p1    <= '0;
            imm_p1   <= '0;
            fmt_p1   <= FMT_R;
            ill_p1   <= 1'b0;
            instr_sk <= '0;
            pc_sk    <= '0;
            imm_sk   <= '0;
            fmt_sk   <= FMT_R;
            ill_sk   <= 1'b0;
        end else begin
            if (ld_main) begin
                if (main_from_skid) begin
                    instr_p1 <= instr_sk;
                    pc_p1    <= pc_sk;
                    imm_p1   <= imm_sk;
                    fmt_p1   <= fmt_sk;
                    ill_p1   <= ill_sk;
                end else begin
                    instr_p1 <= in_instr;
                    pc_p1    <= in_pc;
                    imm_p1   <= imm_p0;
                    fmt_p1   <= fmt_p0;
                    ill_p1   <= ill_p0;
                end
            end
            if (ld_skid) begin
                instr_sk <= in_instr;
                pc_sk    <= in_pc;
                imm_sk   <= imm_p0;
                fmt_sk   <= fmt_p0;
                ill_sk   <= ill_p0;
            end
        end
    end

    // ---- outputs: raw field slices of the registered word ----
    assign out_valid    = vld_p1;
    assign out_pc       = pc_p1;
    assign out_op       = instr_p1[6:0];
    assign out_rd       = instr_p1[11:7];
    assign out_f3       = instr_p1[14:12];
    assign out_rs1      = instr_p1[19:15];
    assign out_rs2      = instr_p1[24:20];
    assign out_f7       = instr_p1[31:25];
    assign out_imm      = imm_p1;
    assign out_imm_type = fmt_p1;
    assign out_illegal  = ill_p1;

endmodule

// File: tb/tb_sr_decode_stage.sv
module tb_sr_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Three instances: [0] XLEN=32/SKID=0, [1] XLEN=32/SKID=1, [2] XLEN=64/SKID=1
    logic [2:0]        iv, ordy, fl;
    logic [2:0][31:0]  ii;
    logic [2:0][63:0]  ip;

    logic [2:0]        o_rdy, o_vld, o_ill;
    logic [2:0][6:0]   o_op, o_f7;
    logic [2:0][4:0]   o_rd, o_rs1, o_rs2;
    logic [2:0][2:0]   o_f3, o_type;
    logic [31:0]       pc0, imm0, pc1, imm1;
    logic [63:0]       pc2, imm2;
    logic [2:0][63:0]  o_pc, o_imm;

    assign o_pc  = {pc2, {32'b0, pc1}, {32'b0, pc0}};
    assign o_imm = {imm2, {32'b0, imm1}, {32'b0, imm0}};

    sr_decode_stage #(.XLEN(32), .SKID(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(o_rdy[0]), .in_instr(ii[0]), .in_pc(ip[0][31:0]),
        .out_valid(o_vld[0]), .out_ready(ordy[0]), .out_pc(pc0),
        .out_op(o_op[0]), .out_rd(o_rd[0]), .out_f3(o_f3[0]), .out_rs1(o_rs1[0]),
        .out_rs2(o_rs2[0]), .out_f7(o_f7[0]), .out_imm(imm0),
        .out_imm_type(o_type[0]), .out_illegal(o_ill[0]));

    sr_decode_stage #(.XLEN(32), .SKID(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(o_rdy[1]), .in_instr(ii[1]), .in_pc(ip[1][31:0]),
        .out_valid(o_vld[1]), .out_ready(ordy[1]), .out_pc(pc1),
        .out_op(o_op[1]), .out_rd(o_rd[1]), .out_f3(o_f3[1]), .out_rs1(o_rs1[1]),
        .out_rs2(o_rs2[1]), .out_f7(o_f7[1]), .out_imm(imm1),
        .out_imm_type(o_type[1]), .out_illegal(o_ill[1]));

    sr_decode_stage #(.XLEN(64), .SKID(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(fl[2]),
        .in_valid(iv[2]), .in_ready(o_rdy[2]), .in_instr(ii[2]), .in_pc(ip[2]),
        .out_valid(o_vld[2]), .out_ready(ordy[2]), .out_pc(pc2),
        .out_op(o_op[2]), .out_rd(o_rd[2]), .out_f3(o_f3[2]), .out_rs1(o_rs1[2]),
        .out_rs2(o_rs2[2]), .out_f7(o_f7[2]), .out_imm(imm2),
        .out_imm_type(o_type[2]), .out_illegal(o_ill[2]));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int xl_of(input int i);
        return (i == 2) ? 64 : 32;
    endfunction

    function automatic bit sk_of(input int i);
        return (i != 0);
    endfunction

    // Reference decode: format from an opcode table, immediate from
    // signed integer arithmetic on the instruction fields.
    function automatic logic [2:0] ref_type(input logic [31:0] w);
        if (w[1:0] != 2'b11) return 3'd7;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
            7'h33:               return 3'd0;
            default:             return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] w, input int xl);
        int     sw;
        int     sgn;
        longint e;
        sw  = int'(w);
        sgn = sw >>> 31;  // -1 or 0
        case (ref_type(w))
            3'd1:    e = longint'(sw >>> 20);
            3'd2:    e = longint'((sw >>> 25) * 32 + int'(w[11:7]));
            3'd3:    e = longint'(sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                                  + int'(w[11:8]) * 2);
            3'd4:    e = longint'(int'(w & 32'hFFFFF000));
            3'd5:    e = longint'(sgn * 1048576 + int'(w[19:12]) * 4096
                                  + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default: e = 0;
        endcase
        if (xl == 32) return {32'b0, e[31:0]};
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:  w[6:0] = 7'h03;
            1:  w[6:0] = 7'h13;
            2:  w[6:0] = 7'h67;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h37;
            6:  w[6:0] = 7'h17;
            7:  w[6:0] = 7'h6F;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h0B;
            10: w[1:0] = 2'($urandom_range(0, 2));
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard: per instance, an in-order FIFO of accepted {pc, instr}.
    // The front entry is what the outputs must show.
    logic [95:0] mq [3][16];
    int          head [3];
    int          cnt  [3];
    int          ocnt [3];
    logic [2:0]  acc;

    always @(posedge clk) begin
        bit push, pop;
        for (int i = 0; i < 3; i++) begin
            push = iv[i] && o_rdy[i];
            pop  = o_vld[i] && ordy[i] && (cnt[i] > 0);
            acc[i] <= push;
            if (!rst_n) begin
                cnt[i]  <= 0;
                head[i] <= 0;
            end else if (fl[i]) begin
                cnt[i] <= 0;
            end else begin
                if (push && cnt[i] < 16)
                    mq[i][(head[i] + cnt[i]) % 16] <= {ip[i], ii[i]};
                head[i] <= (head[i] + int'(pop)) % 16;
                cnt[i]  <= cnt[i] + int'(push && cnt[i] < 16) - int'(pop);
                ocnt[i] <= ocnt[i] + int'(pop);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] w;
        logic [63:0] p;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.valid", i), 64'(o_vld[i]), 64'(cnt[i] > 0));
                chk($sformatf("u%0d.in_ready", i), 64'(o_rdy[i]),
                    64'(sk_of(i) ? (cnt[i] < 2) : (cnt[i] == 0 || ordy[i])));
                if (cnt[i] > 0) begin
                    w = mq[i][head[i]][31:0];
                    p = mq[i][head[i]][95:32];
                    chk($sformatf("u%0d.pc", i), o_pc[i], p);
                    chk($sformatf("u%0d.fields", i),
                        64'({o_f7[i], o_rs2[i], o_rs1[i], o_f3[i], o_rd[i], o_op[i]}), 64'(w));
                    chk($sformatf("u%0d.imm", i), o_imm[i], ref_imm(w, xl_of(i)));
                    chk($sformatf("u%0d.type", i), 64'(o_type[i]), 64'(ref_type(w)));
                    chk($sformatf("u%0d.illegal", i), 64'(o_ill[i]), 64'(ref_type(w) == 3'd7));
                end
            end
        end
    end

    task automatic send_one(input logic [31:0] w, input logic [63:0] pc);
        @(posedge clk);
        #1;
        iv   = 3'b111;
        ordy = 3'b111;
        ii   = {w, w, w};
        ip   = {pc, pc, pc};
        @(posedge clk);
        #1;
        iv = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] seq_w [8];
    int          idx   [3];
    int          base  [3];
    logic        r1, r2;
    bit          done;
    int          cyc;

    initial begin
        rst_n = 1'b0;
        iv = '0; ordy = '0; fl = '0; ii = '0; ip = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Asynchronous reset while a bundle is valid
        send_one(32'h0020A423, 64'h200);
        chk("pre_reset.valid", 64'(o_vld[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst.u%0d.valid", i), 64'(o_vld[i]), 64'd0);
            chk($sformatf("rst.u%0d.pc", i), o_pc[i], 64'd0);
            chk($sformatf("rst.u%0d.imm", i), o_imm[i], 64'd0);
            chk($sformatf("rst.u%0d.type", i), 64'(o_type[i]), 64'd0);
            chk($sformatf("rst.u%0d.illegal", i), 64'(o_ill[i]), 64'd0);
            chk($sformatf("rst.u%0d.fields", i),
                64'({o_f7[i], o_rs2[i], o_rs1[i], o_f3[i], o_rd[i], o_op[i]}), 64'd0);
            chk($sformatf("rst.u%0d.in_ready", i), 64'(o_rdy[i]), 64'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Format table
        send_one(32'hFFF00093, 64'h100);
        chk("I.imm", o_imm[0], 64'hFFFFFFFF);
        chk("I.type", 64'(o_type[0]), 64'd1);
        chk("I.rd", 64'(o_rd[0]), 64'd1);
        chk("I.pc", o_pc[0], 64'h100);
        chk("I.imm64", o_imm[2], 64'hFFFFFFFFFFFFFFFF);

        send_one(32'h0020A423, 64'h104);
        chk("S.type", 64'(o_type[0]), 64'd2);
        chk("S.imm", o_imm[0], 64'h8);
        chk("S.rs1", 64'(o_rs1[0]), 64'd1);
        chk("S.rs2", 64'(o_rs2[0]), 64'd2);
        chk("S.f3", 64'(o_f3[0]), 64'd2);

        send_one(32'hFE000EE3, 64'h108);
        chk("B.type", 64'(o_type[0]), 64'd3);
        chk("B.imm", o_imm[0], 64'hFFFFFFFC);

        send_one(32'h123452B7, 64'h10C);
        chk("U.type", 64'(o_type[0]), 64'd4);
        chk("U.imm", o_imm[0], 64'h12345000);
        chk("U.rd", 64'(o_rd[0]), 64'd5);

        send_one(32'h001000EF, 64'h110);
        chk("J.type", 64'(o_type[0]), 64'd5);
        chk("J.imm", o_imm[0], 64'h800);

        send_one(32'h800000B7, 64'h114);
        chk("U64.imm", o_imm[2], 64'hFFFFFFFF80000000);
        chk("U32.imm", o_imm[0], 64'h80000000);

        send_one(32'h00000000, 64'h118);
        chk("ILL64.illegal", 64'(o_ill[2]), 64'd1);
        chk("ILL64.type", 64'(o_type[2]), 64'd7);
        chk("ILL64.imm", o_imm[2], 64'd0);
        chk("ILL64.valid", 64'(o_vld[2]), 64'd1);

        // Back-pressure: 8 instructions per instance, random out_ready
        @(posedge clk);
        #1 ordy = 3'b111;
        @(posedge clk);
        for (int k = 0; k < 8; k++) seq_w[k] = rnd_instr();
        for (int i = 0; i < 3; i++) begin
            idx[i]  = 0;
            base[i] = ocnt[i];
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) idx[i]++;
                if (idx[i] < 8) begin
                    iv[i] = 1'b1;
                    ii[i] = seq_w[idx[i]];
                    ip[i] = 64'h1000 + 64'(4 * idx[i]);
                end else begin
                    iv[i] = 1'b0;
                end
                ordy[i] = 1'($urandom_range(0, 1));
            end
            r1 = o_rdy[1];
            r2 = o_rdy[2];
            ordy[1] = ~ordy[1];
            ordy[2] = ~ordy[2];
            #1;
            chk("u1.rdy_indep", 64'(o_rdy[1]), 64'(r1));
            chk("u2.rdy_indep", 64'(o_rdy[2]), 64'(r2));
            ordy[1] = ~ordy[1];
            ordy[2] = ~ordy[2];
            #1;
            done = 1'b1;
            for (int i = 0; i < 3; i++)
                if (ocnt[i] - base[i] < 8) done = 1'b0;
            cyc++;
        end
        iv = 3'b000;
        for (int i = 0; i < 3; i++)
            chk($sformatf("stream.u%0d.count", i), 64'(ocnt[i] - base[i]), 64'd8);
        ordy = 3'b111;
        repeat (3) @(posedge clk);

        // Flush with both skid entries full and an instruction offered
        #1;
        ordy = 3'b000;
        iv   = 3'b111;
        ii   = {3{32'h00500113}};
        ip   = {3{64'h300}};
        @(posedge clk);
        #1;
        ii = {3{32'h00A00193}};
        ip = {3{64'h304}};
        @(posedge clk);
        #1;
        chk("skid_full.u1.in_ready", 64'(o_rdy[1]), 64'd0);
        chk("skid_full.u2.in_ready", 64'(o_rdy[2]), 64'd0);
        ii = {3{32'h00F00213}};
        ip = {3{64'h308}};
        fl = 3'b111;
        @(posedge clk);
        #1;
        fl = 3'b000;
        iv = 3'b000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("flush.u%0d.valid", i), 64'(o_vld[i]), 64'd0);
            chk($sformatf("flush.u%0d.in_ready", i), 64'(o_rdy[i]), 64'd1);
        end
        ordy = 3'b111;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                chk($sformatf("flush.u%0d.no_ghost", i), 64'(o_vld[i]), 64'd0);
        end

        // Randomized traffic with occasional flushes
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                ii[i]   = rnd_instr();
                ip[i]   = (i == 2) ? {32'($urandom), 32'($urandom)} : {32'b0, 32'($urandom)};
                ordy[i] = ($urandom_range(0, 2) != 0);
                fl[i]   = ($urandom_range(0, 24) == 0);
            end
        end
        @(posedge clk);
        #1;
        iv   = 3'b000;
        fl   = 3'b000;
        ordy = 3'b111;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_decode_stage.md
Name: sr_decode_stage

Overview:
- Registered, parameterised instruction-decode pipeline stage for the schoolRISCV core.
- Accepts fetched instruction words over a valid/ready handshake and splits out the register and function fields.
- Selects and sign-extends the correct immediate (I/S/B/U/J) to XLEN, classifies the instruction format and flags illegal encodings.
- Sits between fetch and execute; supports back-pressure, optional skid buffering and synchronous flush on branch redirect.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets the width of `imm`, `in_pc` and `out_pc`.
- SKID, 0, 0 = single pipeline register; 1 = two-entry skid buffer with registered `in_ready`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction.
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  PC of the instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  XLEN  PC of the decoded instruction.
- out_op  output  7  instr[6:0].
- out_rd  output  5  instr[11:7].
- out_f3  output  3  instr[14:12].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_f7  output  7  instr[31:25].
- out_imm  output  XLEN  selected immediate, sign-extended.
- out_imm_type  output  3  instruction format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  output  1  unsupported or illegal encoding.

Behaviour:
- Reset (rst_n=0, asynchronous): all valid flags clear; every output register is 0; `out_imm_type`=0. With SKID=1, `in_ready`=1 after reset.
- A transfer occurs on the rising edge where valid && ready on that interface.
- Latency: the decoded bundle appears on the outputs 1 cycle after the input transfer.
- SKID=0:
  - `in_ready` = !out_valid || out_ready (combinational).
  - On an input transfer the register loads the new bundle.
  - On an output transfer with no input transfer, `out_valid` clears.
- SKID=1:
  - Main register plus skid register; `in_ready` is a flop equal to "skid register empty".
  - Input accepted while main is full and out_ready=0 goes to the skid register.
  - On the next output transfer the skid register moves to main.
  - No instruction is ever dropped or duplicated; order is preserved.
- While out_valid=1 && out_ready=0, all out_* fields are held stable.
- Flush:
  - Clears all valid flags at the next edge; skid contents are discarded.
  - An input offered in the same cycle as flush is consumed and dropped (in_ready semantics unchanged).
  - Flush has priority over out_ready.
- Immediate selection by opcode:
  - 0000011 (LOAD), 0010011 (OP-IMM), 1100111 (JALR): I-type, imm = sext(instr[31:20]).
  - 0100011 (STORE): S-type, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 (BRANCH): B-type, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111 (LUI), 0010111 (AUIPC): U-type, imm = sext({instr[31:12], 12'b0}).
  - 1101111 (JAL): J-type, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 (OP): R-type, imm = 0.
  - Any other opcode, or instr[1:0] != 2'b11: type ILL, out_illegal=1, imm = 0.
- Sign extension always comes from instr[31], up to XLEN. For XLEN=64, U-type is sign-extended from bit 31.
- An illegal instruction still flows through the handshake as a normal bundle; it is never stalled or dropped by this stage.
- Field outputs (rd/rs1/rs2/f3/f7/op) are raw slices of the registered instruction, regardless of format.

Test Plan:
- Reset, XLEN=32: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately (asynchronous), all outputs 0; release, send 0xFFF00093 @pc=0x100 -> next cycle out_imm=0xFFFFFFFF, type=1, rd=1, out_pc=0x100.
- Formats, XLEN=32:
  - 0x0020A423 -> type=2, imm=0x8, rs1=1, rs2=2, f3=2.
  - 0xFE000EE3 -> type=3, imm=0xFFFFFFFC.
  - 0x123452B7 -> type=4, imm=0x12345000, rd=5.
  - 0x001000EF -> type=5, imm=0x800.
- XLEN=64: 0x800000B7 -> imm=0xFFFFFFFF80000000; 0x00000000 -> illegal=1, type=7, imm=0.
- Back-pressure, SKID=0 and SKID=1: stream 8 instructions with out_ready toggling on a random pattern -> exactly the 8 PCs emerge in order, bundles stable while stalled. With SKID=1, in_ready never depends combinationally on out_ready.
- Flush: SKID=1 with both entries full and out_ready=0, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered instruction never appears at the output.
